// File: rtl/freq_ratio_meter.sv
// freq_ratio_meter: measures period/high time of sig_in in clk_in cycles, with lock and timeout.
// Optional input synchronizer enabled by defining FREQ_RATIO_METER_SYNC_EN.
module freq_ratio_meter #(
   parameter int CNT_W    = 8,
   parameter int LOCK_CNT = 3,
   parameter int TIMEOUT  = 255
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period_out,
   output logic [CNT_W-1:0] high_out,
   output logic             meas_valid,
   output logic             locked,
   output logic             timeout
);
   typedef enum logic {WAIT, MEAS} state_t;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] TO_V    = CNT_W'(TIMEOUT);
   localparam logic [3:0]       LC      = 4'(LOCK_CNT);

   state_t           state_q, state_d;
   logic             s, s_d_q, rise;
   logic [CNT_W-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d, period_q, period_d, high_q, high_d;
   logic [3:0]       match_q, match_d;
   logic             valid_q, valid_d, locked_q, locked_d, timeout_q, timeout_d;

`ifdef FREQ_RATIO_METER_SYNC_EN
   logic [1:0] sync_q, sync_d;
   // two-flop synchronizer ahead of edge detection
   always_comb sync_d = {sync_q[0], sig_in};
   always_ff @(posedge clk_in or negedge rst_n)
      if (!rst_n) sync_q <= '0;
      else        sync_q <= sync_d;
   assign s = sync_q[1];
`else
   assign s = sig_in;
`endif

   assign rise = s & ~s_d_q;

   // next-state: measurement on each rise, counting between rises, timeout back to WAIT
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hcnt_d    = hcnt_q;
      period_d  = period_q;
      high_d    = high_q;
      match_d   = match_q;
      valid_d   = 1'b0;
      timeout_d = rise ? 1'b0 : timeout_q;
      if (rise) begin
         cnt_d   = CNT_W'(1);
         hcnt_d  = CNT_W'(1);
         state_d = MEAS;
         if (state_q == MEAS) begin
            period_d = cnt_q;
            high_d   = hcnt_q;
            valid_d  = 1'b1;
            // a zero match count marks the first measurement after WAIT
            match_d  = (match_q != 4'd0 && cnt_q == period_q) ?
                       ((match_q == LC) ? LC : match_q + 4'd1) : 4'd1;
         end
      end else if (state_q == MEAS) begin
         if (cnt_q == TO_V) begin
            timeout_d = 1'b1;
            match_d   = 4'd0;
            state_d   = WAIT;
         end else begin
            cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            hcnt_d = (s && hcnt_q != CNT_MAX) ? hcnt_q + CNT_W'(1) : hcnt_q;
         end
      end
      locked_d = (match_d == LC);
   end

   // state and result registers
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= WAIT;
         s_d_q     <= 1'b0;
         cnt_q     <= '0;
         hcnt_q    <= '0;
         period_q  <= '0;
         high_q    <= '0;
         match_q   <= '0;
         valid_q   <= 1'b0;
         locked_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         s_d_q     <= s;
         cnt_q     <= cnt_d;
         hcnt_q    <= hcnt_d;
         period_q  <= period_d;
         high_q    <= high_d;
         match_q   <= match_d;
         valid_q   <= valid_d;
         locked_q  <= locked_d;
         timeout_q <= timeout_d;
      end
   end

   assign period_out = period_q;
   assign high_out   = high_q;
   assign meas_valid = valid_q;
   assign locked     = locked_q;
   assign timeout    = timeout_q;
endmodule

// File: doc/freq_ratio_meter.md
# freq_ratio_meter

Measures the period and high time of a divided clock against the reference clock, in reference-clock cycles. It reports each measurement, declares lock after a run of identical periods, and flags loss of activity. It sits on the receiving end of the frequency-divider outputs (2x/3x/4x/5x) and closes the loop on divider ratio and duty in simulation and on silicon debug.

## Interface
Parameters:
- CNT_W, 8: width of cycle counters and result outputs.
- LOCK_CNT, 3: number of consecutive identical periods required to assert lock (range 2..15).
- TIMEOUT, 255: cycles without a rising edge before timeout (must be ≤ 2^CNT_W−1).

Ports:
- clk_in, input, 1: the only clock; all logic on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- sig_in, input, 1: divided clock under measurement.
- period_out, output, CNT_W: last measured period in clk_in cycles.
- high_out, output, CNT_W: last measured high time in clk_in cycles.
- meas_valid, output, 1: one-cycle pulse when period_out/high_out update.
- locked, output, 1: LOCK_CNT consecutive identical periods seen.
- timeout, output, 1: no rising edge for TIMEOUT cycles.

## Operation
- s = sampled sig_in (direct, or synchronized; see Configuration). s_d = s delayed one cycle, reset 0. rise = s & ~s_d.
- FSM states:
  - WAIT (reset state): on rise, set cnt=1 and hcnt=1, then go to MEAS. No measurement is produced.
  - MEAS, on rise: period_out<=cnt, high_out<=hcnt, meas_valid<=1, cnt<=1, hcnt<=1.
  - MEAS, no rise: cnt<=cnt+1 saturating; hcnt<=hcnt+s saturating.
  - MEAS, no rise and cnt==TIMEOUT: timeout<=1, locked<=0, match count<=0, go to WAIT. period_out/high_out hold.
- timeout clears on the next rise, including a rise in WAIT.
- Rise and cnt==TIMEOUT in the same cycle: the rise wins. The measurement is taken and no timeout is raised.
- Lock tracking uses a match counter, reset 0:
  - On each measurement, new period == previous period_out: increment, saturating at LOCK_CNT.
  - Otherwise: set to 1.
  - locked = (match count == LOCK_CNT), registered.
  - A mismatching measurement drops locked in the same cycle meas_valid pulses.
- The first measurement after WAIT always sets the match count to 1.
- Reset values: period_out=0, high_out=0, meas_valid=0, locked=0, timeout=0, FSM=WAIT, all counters 0.
- Asserting rst_n low mid-measurement clears everything immediately. Measurement restarts from WAIT.

## Timing
- rise is detected combinationally in cycle T. meas_valid, period_out, high_out and locked update at the end of T and are visible in T+1.
- Latency from sig_in rising edge (sampled) to meas_valid: 1 cycle without sync, 3 cycles with sync.
- meas_valid is exactly one cycle wide. Minimum spacing is 2 cycles (divide-by-2).
- After reset or timeout, the first meas_valid follows the second observed rise.
- The timeout flag rises in the cycle after cnt reaches TIMEOUT.

## Configuration
- FREQ_RATIO_METER_SYNC_EN defined: sig_in passes through a 2-flop synchronizer (reset 0) before edge detection. This is for sig_in from an unrelated or negedge-generated source. It adds 2 cycles of latency and does not change measured values.
- Not defined: sig_in is sampled directly by the edge-detect flop. sig_in must be synchronous to clk_in.

## Test plan
- Divide-by-2 pattern 1,0 repeating, after reset release -> period_out=2, high_out=1, meas_valid every 2 cycles; locked asserts after the 3rd valid (LOCK_CNT=3).
- Divide-by-4 pattern 1,1,0,0 -> period_out=4, high_out=2. Switch mid-run to divide-by-5 pattern 1,1,0,0,0 -> first valid after the switch shows 5/2 with locked=0; locked returns after 3 matching valids.
- Divide-by-3 pattern 1,0,0 -> period_out=3, high_out=1, locked=1 after 3 valids.
- Hold sig_in=0 for 300 cycles while locked, TIMEOUT=255 -> timeout=1 and locked=0; period_out is held. Resume pattern -> timeout clears on the first rise; the next valid follows the second rise.
- Drive rst_n=0 for 1 cycle mid-period while locked -> all outputs 0 at once; after release, no meas_valid until two rises are seen.
- Rise exactly when cnt==TIMEOUT (period 255) -> meas_valid with period_out=255, timeout stays 0.
